// File: rtl/halton_env_pkg.sv
// Shared types for the Halton-sample planning environment: map geometry, points, checker FSM states.
package halton_env_pkg;
  localparam int COORD_W = 10;
  localparam int MAP_W   = 1024;
  localparam int MAP_H   = 1024;

  typedef logic [COORD_W-1:0]        coord_t;
  typedef logic signed [COORD_W+1:0] scoord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } point_t;

  typedef enum logic [1:0] {IDLE, WALK, DRAIN, RESP} state_t;

  function automatic scoord_t to_s(coord_t c);
    return $signed({2'b00, c});
  endfunction
endpackage

// File: rtl/bresenham_stepper.sv
// Bresenham line walker: load latches a segment, each step advances one pixel along it.
module bresenham_stepper
  import halton_env_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  logic   step,
  input  point_t p0,
  input  point_t p1,
  output point_t cur,
  output logic   last
);
  coord_t           x_q, x_d, y_q, y_d;
  scoord_t          dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic             sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
  logic [COORD_W:0] rem_q, rem_d;
  scoord_t          ddx, ddy, adx, ady, mx, e2;

  always_comb begin
    ddx = to_s(p1.x) - to_s(p0.x);
    ddy = to_s(p1.y) - to_s(p0.y);
    adx = ddx[COORD_W+1] ? -ddx : ddx;
    ady = ddy[COORD_W+1] ? -ddy : ddy;
    mx  = (adx >= ady) ? adx : ady;
    e2  = err_q <<< 1;
    x_d = x_q; y_d = y_q; dx_d = dx_q; dy_d = dy_q; err_d = err_q;
    sx_neg_d = sx_neg_q; sy_neg_d = sy_neg_q; rem_d = rem_q;
    if (load) begin
      x_d      = p0.x;
      y_d      = p0.y;
      dx_d     = adx;
      dy_d     = -ady;
      sx_neg_d = ddx[COORD_W+1];
      sy_neg_d = ddy[COORD_W+1];
      err_d    = adx - ady;
      rem_d    = mx[COORD_W:0];
    end else if (step) begin
      // both tests use the pre-update e2, so diagonal moves update x and y together
      if (e2 >= dy_q) begin
        err_d = err_d + dy_q;
        x_d   = sx_neg_q ? x_q - coord_t'(1) : x_q + coord_t'(1);
      end
      if (e2 <= dx_q) begin
        err_d = err_d + dx_q;
        y_d   = sy_neg_q ? y_q - coord_t'(1) : y_q + coord_t'(1);
      end
      rem_d = rem_q - (COORD_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q <= '0; y_q <= '0; dx_q <= '0; dy_q <= '0; err_q <= '0;
      sx_neg_q <= 1'b0; sy_neg_q <= 1'b0; rem_q <= '0;
    end else begin
      x_q <= x_d; y_q <= y_d; dx_q <= dx_d; dy_q <= dy_d; err_q <= err_d;
      sx_neg_q <= sx_neg_d; sy_neg_q <= sy_neg_d; rem_q <= rem_d;
    end
  end

  assign cur  = '{x: x_q, y: y_q};
  assign last = (rem_q == '0);
endmodule

// File: rtl/map_segment_checker.sv
// Walks a segment over the occupancy map RAM, one read per cycle, reporting free/collision and first hit.
module map_segment_checker
  import halton_env_pkg::COORD_W, halton_env_pkg::point_t, halton_env_pkg::state_t,
         halton_env_pkg::IDLE, halton_env_pkg::WALK, halton_env_pkg::DRAIN, halton_env_pkg::RESP;
#(
  parameter int MAP_W = halton_env_pkg::MAP_W,
  parameter int MAP_H = halton_env_pkg::MAP_H
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [COORD_W-1:0] req_x0,
  input  logic [COORD_W-1:0] req_y0,
  input  logic [COORD_W-1:0] req_x1,
  input  logic [COORD_W-1:0] req_y1,
  output logic [COORD_W-1:0] mem_x_addr,
  output logic [COORD_W-1:0] mem_y_addr,
  input  logic               mem_rd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_collision,
  output logic [COORD_W-1:0] rsp_hit_x,
  output logic [COORD_W-1:0] rsp_hit_y,
  output logic [COORD_W:0]   rsp_count
);
  state_t           state_q, state_d;
  logic             pend_q, pend_d, pend_oob_q, pend_oob_d;
  point_t           pend_pt_q, pend_pt_d;
  logic [COORD_W:0] cnt_q, cnt_d, cnt_nx;
  logic             coll_q, coll_d;
  point_t           hit_q, hit_d;
  logic [COORD_W:0] rcnt_q, rcnt_d;
  logic             load, step, last, cur_oob, hit;
  point_t           cur, p0, p1;

  assign p0 = '{x: req_x0, y: req_y0};
  assign p1 = '{x: req_x1, y: req_y1};

  bresenham_stepper u_step (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .step  (step),
    .p0    (p0),
    .p1    (p1),
    .cur   (cur),
    .last  (last)
  );

  // off-map pixels ride the read pipeline as if the RAM had returned 1
  assign cur_oob = (32'(cur.x) >= MAP_W) || (32'(cur.y) >= MAP_H);
  assign hit     = pend_q & (mem_rd_data | pend_oob_q);
  assign cnt_nx  = cnt_q + {{COORD_W{1'b0}}, pend_q};

  always_comb begin
    state_d    = state_q;
    pend_d     = 1'b0;
    pend_pt_d  = pend_pt_q;
    pend_oob_d = pend_oob_q;
    cnt_d      = cnt_q;
    coll_d     = coll_q;
    hit_d      = hit_q;
    rcnt_d     = rcnt_q;
    load       = 1'b0;
    step       = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        load    = 1'b1;
        cnt_d   = '0;
        state_d = WALK;
      end
      WALK: begin
        cnt_d = cnt_nx;
        if (hit) begin
          state_d = RESP;
          coll_d  = 1'b1;
          hit_d   = pend_pt_q;
          rcnt_d  = cnt_nx;
        end else begin
          pend_d     = 1'b1;
          pend_pt_d  = cur;
          pend_oob_d = cur_oob;
          if (last) state_d = DRAIN;
          else      step    = 1'b1;
        end
      end
      DRAIN: begin
        state_d = RESP;
        coll_d  = hit;
        hit_d   = hit ? pend_pt_q : '0;
        rcnt_d  = cnt_nx;
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pend_q     <= 1'b0;
      pend_pt_q  <= '0;
      pend_oob_q <= 1'b0;
      cnt_q      <= '0;
      coll_q     <= 1'b0;
      hit_q      <= '0;
      rcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      pend_pt_q  <= pend_pt_d;
      pend_oob_q <= pend_oob_d;
      cnt_q      <= cnt_d;
      coll_q     <= coll_d;
      hit_q      <= hit_d;
      rcnt_q     <= rcnt_d;
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign rsp_valid     = (state_q == RESP);
  assign rsp_collision = coll_q;
  assign rsp_hit_x     = hit_q.x;
  assign rsp_hit_y     = hit_q.y;
  assign rsp_count     = rcnt_q;
  assign mem_x_addr    = cur.x;
  assign mem_y_addr    = cur.y;
endmodule
